// File: rtl/cci_mpf_csrs_pkg.sv
// MPF CSR shared types: CSR offsets, VTP mode type, line-address width,
// pending-read record and the MMIO address decode helper.
package cci_mpf_csrs_pkg;

  localparam int CCI_CLADDR_WIDTH = 42;
  localparam int VTP_MODE_WIDTH   = 8;

  typedef logic [CCI_CLADDR_WIDTH-1:0] t_line_addr;
  typedef logic [VTP_MODE_WIDTH-1:0]   t_vtp_mode;

  typedef enum logic [2:0] {
    CSR_VTP_MODE         = 3'd0,
    CSR_VTP_PT_BASE      = 3'd1,
    CSR_VTP_HITS         = 3'd2,
    CSR_VTP_MISSES       = 3'd3,
    CSR_WRO_WRITES       = 3'd4,
    CSR_WRO_READS        = 3'd5,
    CSR_WRO_WR_CONFLICTS = 3'd6,
    CSR_WRO_RD_CONFLICTS = 3'd7
  } t_csr_idx;

  typedef struct packed {
    logic     hit;
    t_csr_idx idx;
  } t_csr_dec;

  typedef struct packed {
    logic [15:0] addr;
    logic [8:0]  tid;
  } t_rd_req;

  // CSRs are 8 bytes wide, so only even DWORD offsets 0..14 map.
  // Addresses below the base wrap to large offsets and miss.
  function automatic t_csr_dec csr_decode(
    input logic [15:0] addr,
    input logic [15:0] base
  );
    t_csr_dec    d;
    logic [15:0] off;
    off   = addr - base;
    d.hit = (off[15:4] == 12'h000) && !off[0];
    d.idx = t_csr_idx'(off[3:1]);
    return d;
  endfunction

endpackage

// File: rtl/cci_mpf_csrs_if.sv
// MPF CSR bundle: VTP control inputs and VTP/WRO statistics counters.
// Modports: csr (CSR manager side), mpf (VTP/WRO side).
interface cci_mpf_csrs;
  import cci_mpf_csrs_pkg::*;

  t_vtp_mode   vtp_in_mode;
  t_line_addr  vtp_in_page_table_base;
  logic        vtp_in_page_table_base_valid;

  logic [63:0] vtp_out_num_hits;
  logic [63:0] vtp_out_num_misses;
  logic [63:0] wro_out_num_writes;
  logic [63:0] wro_out_num_reads;
  logic [63:0] wro_out_num_wr_conflicts;
  logic [63:0] wro_out_num_rd_conflicts;

  modport csr (
    output vtp_in_mode,
    output vtp_in_page_table_base,
    output vtp_in_page_table_base_valid,
    input  vtp_out_num_hits,
    input  vtp_out_num_misses,
    input  wro_out_num_writes,
    input  wro_out_num_reads,
    input  wro_out_num_wr_conflicts,
    input  wro_out_num_rd_conflicts
  );

  modport mpf (
    input  vtp_in_mode,
    input  vtp_in_page_table_base,
    input  vtp_in_page_table_base_valid,
    output vtp_out_num_hits,
    output vtp_out_num_misses,
    output wro_out_num_writes,
    output wro_out_num_reads,
    output wro_out_num_wr_conflicts,
    output wro_out_num_rd_conflicts
  );

endinterface

// File: rtl/cci_mpf_csr_rd_fifo.sv
// Pending MMIO read buffer. Ports: clk, rst_n, i_enq/i_data (push),
// i_deq (pop), o_data (head), o_full, o_empty. DEPTH is a power of 2.
module cci_mpf_csr_rd_fifo
  import cci_mpf_csrs_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic    clk,
  input  logic    rst_n,
  input  logic    i_enq,
  input  t_rd_req i_data,
  input  logic    i_deq,
  output t_rd_req o_data,
  output logic    o_full,
  output logic    o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  t_rd_req       r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          w_do_enq;
  logic          w_do_deq;

  assign o_full   = (r_count == FULL_CNT);
  assign o_empty  = (r_count == '0);
  assign o_data   = r_mem[r_rd_ptr];
  assign w_do_deq = i_deq && !o_empty;
  // A push into a full buffer fits only if the head leaves this cycle.
  assign w_do_enq = i_enq && (!o_full || w_do_deq);

  always_ff @(posedge clk) begin
    if (w_do_enq) r_mem[r_wr_ptr] <= i_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_enq) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_deq) r_rd_ptr <= r_rd_ptr + 1'b1;
      unique case ({w_do_enq, w_do_deq})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/cci_mpf_csr_mgr.sv
// MPF MMIO CSR manager: VTP mode/page-table writes, buffered in-order reads.
// Ports: clk, reset_n, mmio_wr_*, mmio_rd_*, rsp_blocked, rsp_*, rd_overflow,
// csrs (cci_mpf_csrs.csr). Define CCI_MPF_CSR_STATS_EN to expose counters.
module cci_mpf_csr_mgr
  import cci_mpf_csrs_pkg::*;
#(
  parameter logic [15:0] CSR_BASE      = 16'h0800,
  parameter int          RD_FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        mmio_wr_valid,
  input  logic [15:0] mmio_wr_addr,
  input  logic [63:0] mmio_wr_data,
  input  logic        mmio_rd_valid,
  input  logic [15:0] mmio_rd_addr,
  input  logic [8:0]  mmio_rd_tid,
  input  logic        rsp_blocked,
  output logic        rsp_valid,
  output logic [8:0]  rsp_tid,
  output logic [63:0] rsp_data,
  output logic        rd_overflow,
  cci_mpf_csrs.csr    csrs
);

  t_vtp_mode   r_mode;
  t_line_addr  r_pt_base;
  logic        r_pt_valid;
  logic        r_rsp_valid;
  logic [8:0]  r_rsp_tid;
  logic [63:0] r_rsp_data;
  logic        r_overflow;

  t_csr_dec    w_wr_dec;
  t_csr_dec    w_rd_dec;
  t_rd_req     w_enq_req;
  t_rd_req     w_head;
  logic        w_full;
  logic        w_empty;
  logic        w_deq;
  logic        w_wr_mode;
  logic        w_wr_base;
  logic [63:0] w_rd_data;
  logic        w_unused;

  assign w_unused = ^mmio_wr_data[63:48];

  assign w_wr_dec  = csr_decode(mmio_wr_addr, CSR_BASE);
  assign w_wr_mode = mmio_wr_valid && w_wr_dec.hit &&
                     (w_wr_dec.idx == CSR_VTP_MODE);
  assign w_wr_base = mmio_wr_valid && w_wr_dec.hit &&
                     (w_wr_dec.idx == CSR_VTP_PT_BASE);

  assign w_enq_req = '{addr: mmio_rd_addr, tid: mmio_rd_tid};
  assign w_deq     = !w_empty && !rsp_blocked;

  cci_mpf_csr_rd_fifo #(
    .DEPTH(RD_FIFO_DEPTH)
  ) u_rd_fifo (
    .clk    (clk),
    .rst_n  (reset_n),
    .i_enq  (mmio_rd_valid),
    .i_data (w_enq_req),
    .i_deq  (w_deq),
    .o_data (w_head),
    .o_full (w_full),
    .o_empty(w_empty)
  );

  assign w_rd_dec = csr_decode(w_head.addr, CSR_BASE);

  // Reads see register state before any same-cycle write lands.
  always_comb begin
    w_rd_data = '0;
    if (w_rd_dec.hit) begin
      unique case (w_rd_dec.idx)
        CSR_VTP_MODE:         w_rd_data = 64'(r_mode);
`ifdef CCI_MPF_CSR_STATS_EN
        CSR_VTP_HITS:         w_rd_data = csrs.vtp_out_num_hits;
        CSR_VTP_MISSES:       w_rd_data = csrs.vtp_out_num_misses;
        CSR_WRO_WRITES:       w_rd_data = csrs.wro_out_num_writes;
        CSR_WRO_READS:        w_rd_data = csrs.wro_out_num_reads;
        CSR_WRO_WR_CONFLICTS: w_rd_data = csrs.wro_out_num_wr_conflicts;
        CSR_WRO_RD_CONFLICTS: w_rd_data = csrs.wro_out_num_rd_conflicts;
`endif
        default:              w_rd_data = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_mode     <= '0;
      r_pt_base  <= '0;
      r_pt_valid <= 1'b0;
    end else begin
      if (w_wr_mode) r_mode <= mmio_wr_data[VTP_MODE_WIDTH-1:0];
      if (w_wr_base) begin
        r_pt_base  <= mmio_wr_data[6 +: CCI_CLADDR_WIDTH];
        r_pt_valid <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rsp_valid <= 1'b0;
      r_rsp_tid   <= '0;
      r_rsp_data  <= '0;
      r_overflow  <= 1'b0;
    end else begin
      r_rsp_valid <= w_deq;
      if (w_deq) begin
        r_rsp_tid  <= w_head.tid;
        r_rsp_data <= w_rd_data;
      end
      if (mmio_rd_valid && w_full && !w_deq) r_overflow <= 1'b1;
    end
  end

  assign csrs.vtp_in_mode                  = r_mode;
  assign csrs.vtp_in_page_table_base       = r_pt_base;
  assign csrs.vtp_in_page_table_base_valid = r_pt_valid;

  assign rsp_valid   = r_rsp_valid;
  assign rsp_tid     = r_rsp_tid;
  assign rsp_data    = r_rsp_data;
  assign rd_overflow = r_overflow;

endmodule

// File: tb/tb_cci_mpf_csr_mgr.sv
// Directed bench for cci_mpf_csr_mgr: CSR writes, read latency/order,
// overflow, unmapped access and asynchronous reset.
module tb_cci_mpf_csr_mgr;
  import cci_mpf_csrs_pkg::*;

  localparam logic [15:0] BASE = 16'h0800;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        mmio_wr_valid;
  logic [15:0] mmio_wr_addr;
  logic [63:0] mmio_wr_data;
  logic        mmio_rd_valid;
  logic [15:0] mmio_rd_addr;
  logic [8:0]  mmio_rd_tid;
  logic        rsp_blocked;
  logic        rsp_valid;
  logic [8:0]  rsp_tid;
  logic [63:0] rsp_data;
  logic        rd_overflow;

  int n_checks = 0;
  int n_fail   = 0;

  cci_mpf_csrs csrs_if();

  cci_mpf_csr_mgr #(
    .CSR_BASE(BASE),
    .RD_FIFO_DEPTH(4)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .mmio_wr_valid(mmio_wr_valid),
    .mmio_wr_addr (mmio_wr_addr),
    .mmio_wr_data (mmio_wr_data),
    .mmio_rd_valid(mmio_rd_valid),
    .mmio_rd_addr (mmio_rd_addr),
    .mmio_rd_tid  (mmio_rd_tid),
    .rsp_blocked  (rsp_blocked),
    .rsp_valid    (rsp_valid),
    .rsp_tid      (rsp_tid),
    .rsp_data     (rsp_data),
    .rd_overflow  (rd_overflow),
    .csrs         (csrs_if)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] st(input logic [63:0] v);
`ifdef CCI_MPF_CSR_STATS_EN
    return v;
`else
    return 64'h0 & v;
`endif
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    mmio_wr_valid = 1'b0;
    mmio_rd_valid = 1'b0;
    rsp_blocked   = 1'b0;
    reset_n = 1'b0;
    step();
    step();
    reset_n = 1'b1;
    step();
  endtask

  task automatic wr(input logic [15:0] a, input logic [63:0] d);
    mmio_wr_valid = 1'b1;
    mmio_wr_addr  = a;
    mmio_wr_data  = d;
    step();
    mmio_wr_valid = 1'b0;
  endtask

  task automatic rd(input logic [15:0] a, input logic [8:0] t);
    mmio_rd_valid = 1'b1;
    mmio_rd_addr  = a;
    mmio_rd_tid   = t;
    step();
    mmio_rd_valid = 1'b0;
  endtask

  task automatic test_reset();
    #2 reset_n = 1'b0;
    #1;
    n_checks++;
    if (rsp_valid !== 1'b0 || rsp_tid !== 9'h0 || rsp_data !== 64'h0) begin
      n_fail++;
      $display("FAIL reset_rsp: got v=%b t=%h d=%h want 0 0 0",
               rsp_valid, rsp_tid, rsp_data);
    end
    n_checks++;
    if (rd_overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ovf: got %b want 0", rd_overflow);
    end
    n_checks++;
    if (csrs_if.vtp_in_mode !== 8'h0 ||
        csrs_if.vtp_in_page_table_base !== 42'h0 ||
        csrs_if.vtp_in_page_table_base_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_vtp: got m=%h b=%h v=%b want 0 0 0",
               csrs_if.vtp_in_mode, csrs_if.vtp_in_page_table_base,
               csrs_if.vtp_in_page_table_base_valid);
    end
    step();
    reset_n = 1'b1;
    step();
    step();
    n_checks++;
    if (rsp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle: got rsp_valid=%b want 0", rsp_valid);
    end
  endtask

  task automatic test_mode();
    wr(BASE, 64'hFFFF_FFFF_FFFF_FFA5);
    n_checks++;
    if (csrs_if.vtp_in_mode !== 8'hA5) begin
      n_fail++;
      $display("FAIL mode_wr: got %h want a5", csrs_if.vtp_in_mode);
    end
    rd(BASE, 9'h011);
    n_checks++;
    if (rsp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL mode_lat1: got rsp_valid=%b want 0", rsp_valid);
    end
    step();
    n_checks++;
    if (rsp_valid !== 1'b1 || rsp_tid !== 9'h011 ||
        rsp_data !== 64'hA5) begin
      n_fail++;
      $display("FAIL mode_rd: got v=%b t=%h d=%h want 1 011 a5",
               rsp_valid, rsp_tid, rsp_data);
    end
    step();
    n_checks++;
    if (rsp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL mode_pulse: got rsp_valid=%b want 0", rsp_valid);
    end
  endtask

  task automatic test_pt_base();
    wr(BASE + 16'd2, 64'h0000_0012_3456_7840);
    n_checks++;
    if (csrs_if.vtp_in_page_table_base !== 42'h0048D159E1 ||
        csrs_if.vtp_in_page_table_base_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL pt_wr: got b=%h v=%b want 0048d159e1 1",
               csrs_if.vtp_in_page_table_base,
               csrs_if.vtp_in_page_table_base_valid);
    end
    rd(BASE + 16'd2, 9'h0AA);
    step();
    n_checks++;
    if (rsp_valid !== 1'b1 || rsp_tid !== 9'h0AA || rsp_data !== 64'h0) begin
      n_fail++;
      $display("FAIL pt_rd: got v=%b t=%h d=%h want 1 0aa 0",
               rsp_valid, rsp_tid, rsp_data);
    end
    wr(BASE + 16'd2, 64'h0);
    n_checks++;
    if (csrs_if.vtp_in_page_table_base !== 42'h0 ||
        csrs_if.vtp_in_page_table_base_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL pt_sticky: got b=%h v=%b want 0 1",
               csrs_if.vtp_in_page_table_base,
               csrs_if.vtp_in_page_table_base_valid);
    end
  endtask

  task automatic test_counters();
    logic [63:0] v [5];
    v[0] = 64'h1234;
    v[1] = 64'hABCD_0001;
    v[2] = 64'h77;
    v[3] = 64'hF00D_0000_0000_0099;
    v[4] = 64'h3;
    csrs_if.vtp_out_num_hits         = 64'h55;
    csrs_if.vtp_out_num_misses       = v[0];
    csrs_if.wro_out_num_writes       = v[1];
    csrs_if.wro_out_num_reads        = v[2];
    csrs_if.wro_out_num_wr_conflicts = v[3];
    csrs_if.wro_out_num_rd_conflicts = v[4];
    rd(BASE + 16'd4, 9'h1A3);
    n_checks++;
    if (rsp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL hits_lat1: got rsp_valid=%b want 0", rsp_valid);
    end
    step();
    n_checks++;
    if (rsp_valid !== 1'b1 || rsp_tid !== 9'h1A3 ||
        rsp_data !== st(64'h55)) begin
      n_fail++;
      $display("FAIL hits_rd: got v=%b t=%h d=%h want 1 1a3 %h",
               rsp_valid, rsp_tid, rsp_data, st(64'h55));
    end
    for (int i = 0; i < 7; i++) begin
      mmio_rd_valid = (i < 5);
      mmio_rd_addr  = BASE + 16'(2 * (i + 3));
      mmio_rd_tid   = 9'(9'h100 + i);
      step();
      if (i >= 1 && i <= 5) begin
        n_checks++;
        if (rsp_valid !== 1'b1 || rsp_tid !== 9'(9'h100 + i - 1) ||
            rsp_data !== st(v[i-1])) begin
          n_fail++;
          $display("FAIL ctr_rd%0d: got v=%b t=%h d=%h want 1 %h %h",
                   i - 1, rsp_valid, rsp_tid, rsp_data,
                   9'(9'h100 + i - 1), st(v[i-1]));
        end
      end
    end
    mmio_rd_valid = 1'b0;
  endtask

  task automatic test_unmapped();
    wr(BASE + 16'd1, 64'h77);
    wr(BASE + 16'h20, 64'h66);
    wr(BASE + 16'h10, 64'h44);
    wr(BASE + 16'd4, 64'h33);
    wr(BASE - 16'd2, 64'h22);
    wr(BASE + 16'd3, 64'hFFFF_FFC0);
    n_checks++;
    if (csrs_if.vtp_in_mode !== 8'hA5 ||
        csrs_if.vtp_in_page_table_base !== 42'h0) begin
      n_fail++;
      $display("FAIL unmap_wr: got m=%h b=%h want a5 0",
               csrs_if.vtp_in_mode, csrs_if.vtp_in_page_table_base);
    end
    rd(BASE + 16'd1, 9'h0F1);
    step();
    n_checks++;
    if (rsp_valid !== 1'b1 || rsp_tid !== 9'h0F1 || rsp_data !== 64'h0) begin
      n_fail++;
      $display("FAIL unmap_odd: got v=%b t=%h d=%h want 1 0f1 0",
               rsp_valid, rsp_tid, rsp_data);
    end
    rd(BASE + 16'h20, 9'h0F2);
    step();
    n_checks++;
    if (rsp_valid !== 1'b1 || rsp_tid !== 9'h0F2 || rsp_data !== 64'h0) begin
      n_fail++;
      $display("FAIL unmap_20: got v=%b t=%h d=%h want 1 0f2 0",
               rsp_valid, rsp_tid, rsp_data);
    end
    rd(BASE + 16'h10, 9'h0F3);
    step();
    n_checks++;
    if (rsp_valid !== 1'b1 || rsp_tid !== 9'h0F3 || rsp_data !== 64'h0) begin
      n_fail++;
      $display("FAIL unmap_10: got v=%b t=%h d=%h want 1 0f3 0",
               rsp_valid, rsp_tid, rsp_data);
    end
  endtask

  task automatic test_same_cycle();
    rd(BASE, 9'h055);
    wr(BASE, 64'h3C);
    n_checks++;
    if (rsp_valid !== 1'b1 || rsp_tid !== 9'h055 ||
        rsp_data !== 64'hA5) begin
      n_fail++;
      $display("FAIL same_old: got v=%b t=%h d=%h want 1 055 a5",
               rsp_valid, rsp_tid, rsp_data);
    end
    rd(BASE, 9'h056);
    step();
    n_checks++;
    if (rsp_valid !== 1'b1 || rsp_data !== 64'h3C) begin
      n_fail++;
      $display("FAIL same_new: got v=%b d=%h want 1 3c",
               rsp_valid, rsp_data);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    wr(BASE, 64'h5A);
    rsp_blocked = 1'b1;
    for (int i = 0; i < 5; i++) begin
      rd(BASE, 9'(i + 1));
      n_checks++;
      if (rd_overflow !== (i == 4) || rsp_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL ovf_fill%0d: got ovf=%b v=%b want %b 0",
                 i, rd_overflow, rsp_valid, (i == 4));
      end
    end
    step();
    rsp_blocked = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      n_checks++;
      if (rsp_valid !== 1'b1 || rsp_tid !== 9'(i + 1) ||
          rsp_data !== 64'h5A) begin
        n_fail++;
        $display("FAIL ovf_drain%0d: got v=%b t=%h d=%h want 1 %h 5a",
                 i, rsp_valid, rsp_tid, rsp_data, 9'(i + 1));
      end
    end
    step();
    n_checks++;
    if (rsp_valid !== 1'b0 || rd_overflow !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_end: got v=%b ovf=%b want 0 1",
               rsp_valid, rd_overflow);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    rsp_blocked = 1'b1;
    for (int i = 0; i < 4; i++) rd(BASE, 9'(9'h21 + i));
    rsp_blocked   = 1'b0;
    mmio_rd_valid = 1'b1;
    mmio_rd_addr  = BASE;
    mmio_rd_tid   = 9'h25;
    step();
    mmio_rd_valid = 1'b0;
    for (int j = 0; j < 5; j++) begin
      if (j > 0) step();
      n_checks++;
      if (rsp_valid !== 1'b1 || rsp_tid !== 9'(9'h21 + j) ||
          rd_overflow !== 1'b0) begin
        n_fail++;
        $display("FAIL b2b%0d: got v=%b t=%h ovf=%b want 1 %h 0",
                 j, rsp_valid, rsp_tid, rd_overflow, 9'(9'h21 + j));
      end
    end
    step();
    n_checks++;
    if (rsp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_end: got rsp_valid=%b want 0", rsp_valid);
    end
  endtask

  task automatic test_reset_midop();
    wr(BASE, 64'h77);
    wr(BASE + 16'd2, 64'h1000);
    rsp_blocked = 1'b1;
    for (int i = 0; i < 3; i++) rd(BASE, 9'(9'h31 + i));
    rsp_blocked = 1'b0;
    step();
    n_checks++;
    if (rsp_valid !== 1'b1 || rsp_tid !== 9'h31 || rsp_data !== 64'h77) begin
      n_fail++;
      $display("FAIL rst_pre: got v=%b t=%h d=%h want 1 031 77",
               rsp_valid, rsp_tid, rsp_data);
    end
    #2 reset_n = 1'b0;
    #1;
    n_checks++;
    if (rsp_valid !== 1'b0 || rsp_tid !== 9'h0 || rsp_data !== 64'h0) begin
      n_fail++;
      $display("FAIL rst_async: got v=%b t=%h d=%h want 0 0 0",
               rsp_valid, rsp_tid, rsp_data);
    end
    n_checks++;
    if (csrs_if.vtp_in_mode !== 8'h0 ||
        csrs_if.vtp_in_page_table_base !== 42'h0 ||
        csrs_if.vtp_in_page_table_base_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_vtp: got m=%h b=%h v=%b want 0 0 0",
               csrs_if.vtp_in_mode, csrs_if.vtp_in_page_table_base,
               csrs_if.vtp_in_page_table_base_valid);
    end
    step();
    step();
    reset_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      n_checks++;
      if (rsp_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL rst_drop%0d: got rsp_valid=%b want 0", i, rsp_valid);
      end
    end
  endtask

  initial begin
    reset_n       = 1'b1;
    mmio_wr_valid = 1'b0;
    mmio_wr_addr  = '0;
    mmio_wr_data  = '0;
    mmio_rd_valid = 1'b0;
    mmio_rd_addr  = '0;
    mmio_rd_tid   = '0;
    rsp_blocked   = 1'b0;
    csrs_if.vtp_out_num_hits         = '0;
    csrs_if.vtp_out_num_misses       = '0;
    csrs_if.wro_out_num_writes       = '0;
    csrs_if.wro_out_num_reads        = '0;
    csrs_if.wro_out_num_wr_conflicts = '0;
    csrs_if.wro_out_num_rd_conflicts = '0;
    test_reset();
    test_mode();
    test_pt_base();
    test_counters();
    test_unmapped();
    test_same_cycle();
    test_overflow();
    test_back_to_back();
    test_reset_midop();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cci_mpf_csr_mgr.md
CCI_MPF_CSR_MGR -- requirements
Module: cci_mpf_csr_mgr

Interface
REQ-001 SHALL have parameter CSR_BASE, default 16'h0800, DWORD MMIO address of the MPF CSR window.
REQ-002 SHALL have parameter RD_FIFO_DEPTH, default 4, depth of the pending-read buffer (power of 2, at least 2).
REQ-003 SHALL have ports:
  clk  in  1  clock.
  reset_n  in  1  asynchronous, active-low reset.
  mmio_wr_valid  in  1  MMIO write strobe.
  mmio_wr_addr  in  16  DWORD address.
  mmio_wr_data  in  64  write data.
  mmio_rd_valid  in  1  MMIO read request.
  mmio_rd_addr  in  16  DWORD address.
  mmio_rd_tid  in  9  transaction ID.
  rsp_blocked  in  1  response port in use by another agent this cycle.
  rsp_valid  out  1  read response strobe.
  rsp_tid  out  9  echoed TID.
  rsp_data  out  64  read data.
  rd_overflow  out  1  sticky flag: a read was dropped.
  csrs  cci_mpf_csrs.csr modport  drives VTP inputs, samples VTP/WRO counters.

Function
REQ-004 SHALL decode 8-byte CSRs at offset k = (addr - CSR_BASE)/2, for k = 0..7; odd DWORD addresses and addresses outside 0..7 SHALL be unmapped.
REQ-005 Map: 0 VTP_MODE (RW); 1 VTP_PT_BASE (W, reads 0); 2 VTP hits; 3 VTP misses; 4 WRO writes; 5 WRO reads; 6 WRO write conflicts; 7 WRO read conflicts (2-7 RO).
REQ-006 Write to VTP_MODE SHALL load vtp_in_mode from mmio_wr_data low bits, effective the next cycle.
REQ-007 Write to VTP_PT_BASE SHALL load vtp_in_page_table_base = mmio_wr_data >> 6 (truncated to line-address width) and set vtp_in_page_table_base_valid, which stays 1 until reset.
REQ-008 Writes to RO or unmapped addresses SHALL be ignored.
REQ-009 Every accepted read (mapped or not) SHALL produce exactly one response; unmapped reads return 0.
REQ-010 Reads SHALL be enqueued (addr, tid) in the FIFO at the request cycle, with no backpressure.
REQ-011 Head dequeue SHALL occur when FIFO non-empty and rsp_blocked=0; data SHALL be sampled from the live CSR/counter values at the dequeue cycle and registered.
REQ-012 rsp_valid SHALL pulse for one cycle the cycle after dequeue; latency is 2 cycles from request into an empty, unblocked FIFO.
REQ-013 Responses SHALL be in request order.
REQ-014 Enqueue when full without simultaneous dequeue SHALL drop the request and set rd_overflow; enqueue and dequeue in the same full cycle SHALL succeed.
REQ-015 A same-cycle write and read of VTP_MODE SHALL return the pre-write value if dequeued that cycle.
REQ-016 FIFO pointers SHALL wrap modulo RD_FIFO_DEPTH; the occupancy counter SHALL be log2(depth)+1 bits.

Reset
REQ-017 On reset_n low, asynchronously: vtp_in_mode = 0; vtp_in_page_table_base = 0; vtp_in_page_table_base_valid = 0; FIFO empty; rsp_valid = 0; rsp_tid = 0; rsp_data = 0; rd_overflow = 0.
REQ-018 Reset mid-operation SHALL discard all pending reads with no response.

Configuration
REQ-019 With CCI_MPF_CSR_STATS_EN defined, offsets 2-7 SHALL return the counter inputs; without it, they SHALL read 0 and the counter inputs SHALL be unused.

Structure
REQ-020 CSR offsets, the mode type, and the line-address width SHALL live in cci_mpf_csrs_pkg.
REQ-021 The pending-read buffer SHALL be sub-module cci_mpf_csr_rd_fifo (enq, deq, full, empty, data).

Verification
REQ-022 Write 0x0000_0012_3456_7840 to PT_BASE: next cycle base = 0x48D159E1, valid = 1; a read of PT_BASE returns 0.
REQ-023 Read hits with vtp_out_num_hits = 0x55 and tid 0x1A3, FIFO empty: rsp_valid at +2 with tid 0x1A3 and data 0x55 (0 with the macro undefined).
REQ-024 Five back-to-back reads with rsp_blocked = 1 and depth 4: the 5th is dropped and rd_overflow = 1; after unblocking, 4 in-order responses arrive on consecutive cycles.
REQ-025 Read at CSR_BASE+1 and at CSR_BASE+0x20: each yields a response with data 0; writes there change nothing.
REQ-026 Assert reset_n low with 3 pending reads: outputs clear immediately and no responses arrive after release.
